// File: rtl/shift_left_gate.sv
// shift_left_gate
//   Registered logical shift-left unit for the N-bit ALU datapath.
//   A_num is shifted left by the unsigned amount in B_num, with zeros filled
//   in from the LSB. The result is registered together with the sign, carry,
//   zero and signed-overflow flags. The result appears one clock after the
//   operands are presented.
//
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (has priority over valid_in)
//   valid_in  : operands are valid this cycle and are captured
//   A_num     : value to be shifted (N bits)
//   B_num     : shift amount, unsigned (N bits)
//   result    : A_num << B_num, truncated to N bits (registered)
//   sign      : result[N-1] (registered)
//   carry     : last bit shifted out of the MSB (registered)
//   zero      : result == 0 (registered; resets to 0)
//   overflow  : two's-complement overflow of the shift (registered)
//   valid_out : outputs were updated on the last edge
module shift_left_gate #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [N-1:0] A_num,
  input  logic [N-1:0] B_num,
  output logic [N-1:0] result,
  output logic         sign,
  output logic         carry,
  output logic         zero,
  output logic         overflow,
  output logic         valid_out
);

  // Enough stages to shift by any amount up to and including N, because the
  // carry for s == N still has to be produced by the shifter.
  localparam int unsigned STAGES = $clog2(N + 1);
  localparam int unsigned DW     = 2 * N - 2;
  localparam logic [N-1:0] N_VAL = N[N-1:0];

  logic [N:0]    ext;       // {carry slot, A_num} shifted together
  logic [DW-1:0] dx;        // neighbour-difference bits, zero-extended on top
  logic [N-2:0]  diff;
  logic          below_n;
  logic          in_range;
  logic [N-1:0]  res_c;
  logic          carry_c;
  logic          ovf_c;

  // Overflow detection: diff[i] marks A_num[i+1] != A_num[i]. After shifting
  // diff left by s, the bits that land in the upper half are exactly
  // diff[N-2:N-1-s], so any set bit there means the top s+1 bits of A_num
  // were not all equal. For s == 0 nothing reaches the upper half.
  always_comb begin
    diff = A_num[N-1:1] ^ A_num[N-2:0];
    ext  = {1'b0, A_num};
    dx   = {{(N-1){1'b0}}, diff};
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (B_num[k]) begin
        ext = ext << (1 << k);
        dx  = dx << (1 << k);
      end
    end
    below_n  = (B_num < N_VAL);
    in_range = (B_num <= N_VAL);
    res_c    = below_n ? ext[N-1:0] : '0;
    carry_c  = in_range & ext[N];
    ovf_c    = below_n ? (|dx[DW-1:N-1]) : (|A_num);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      sign      <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        result   <= res_c;
        sign     <= res_c[N-1];
        carry    <= carry_c;
        zero     <= (res_c == '0);
        overflow <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_shift_left_gate.sv
// Scoreboard bench for shift_left_gate (N = 6): the driver pushes the
// reference result for every accepted operand set, and a monitor on the
// falling edge pops and compares whenever valid_out is high. When valid_out is
// low, the monitor checks that the registers hold the driver's model state.
module tb_shift_left_gate;

  localparam int N = 6;

  typedef struct packed {
    logic [N-1:0] r;
    logic         s;
    logic         c;
    logic         z;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid_in = 1'b0;
  logic [N-1:0] A_num = '0;
  logic [N-1:0] B_num = '0;
  logic [N-1:0] result;
  logic         sign, carry, zero, overflow, valid_out;

  int checks = 0;
  int failures = 0;
  int pushed = 0;
  int pulses = 0;
  bit mon_en = 1'b0;
  exp_t q[$];
  exp_t st = '0;   // what the output registers should currently hold

  shift_left_gate #(.N(N)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .A_num(A_num), .B_num(B_num),
    .result(result), .sign(sign), .carry(carry), .zero(zero),
    .overflow(overflow), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  // Reference model written straight from the arithmetic definition.
  function automatic exp_t model(input int unsigned a, input int unsigned s);
    exp_t e;
    int unsigned res, t, ones;
    res  = (s < N) ? ((a << s) & ((1 << N) - 1)) : 0;
    e.r  = res[N-1:0];
    e.s  = res[N-1];
    e.z  = (res == 0);
    if (s == 0 || s > N) e.c = 1'b0;
    else                 e.c = ((a >> (N - s)) & 1) != 0;
    if (s == 0) e.o = 1'b0;
    else if (s < N) begin
      t    = a >> (N - 1 - s);
      ones = (1 << (s + 1)) - 1;
      e.o  = !(t == 0 || t == ones);
    end else e.o = (a != 0);
    return e;
  endfunction

  task automatic cycle(input bit r, input bit v, input logic [N-1:0] a,
                       input logic [N-1:0] b);
    exp_t e;
    rst = r; valid_in = v; A_num = a; B_num = b;
    @(posedge clk);
    if (r) st = '0;
    else if (v) begin
      e = model(a, b);
      q.push_back(e);
      pushed++;
      st = e;
    end
    #1;
  endtask

  // Monitor
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        got = {result, sign, carry, zero, overflow};
        checks++;
        if (valid_out) begin
          pulses++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_valid_out got=%b expected no output", got);
          end else begin
            e = q.pop_front();
            if (got !== e) begin
              failures++;
              $display("FAIL result_flags A=%b B=%b got=%b expected=%b (r,s,c,z,o)",
                       A_num, B_num, got, e);
            end
          end
        end else if (got !== st || q.size() != 0) begin
          failures++;
          $display("FAIL hold_or_missing got=%b expected=%b valid_out=%b pending=%0d",
                   got, st, valid_out, q.size());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] a, b;
    bit r, v;
    // Reset with a valid operand set present: it must be discarded.
    cycle(1'b1, 1'b1, 6'b111111, 6'd1);
    mon_en = 1'b1;
    cycle(1'b0, 1'b0, '0, '0);
    // Directed cases
    cycle(1'b0, 1'b1, 6'b001100, 6'd2);
    cycle(1'b0, 1'b1, 6'b000011, 6'd3);
    cycle(1'b0, 1'b1, 6'b111000, 6'd2);
    cycle(1'b0, 1'b1, 6'b000001, 6'd6);
    cycle(1'b0, 1'b1, 6'b101010, 6'd0);
    cycle(1'b0, 1'b1, 6'b000000, 6'b111111);
    cycle(1'b0, 1'b1, 6'b100000, 6'd7);
    cycle(1'b0, 1'b1, 6'b110101, 6'd5);
    // Hold, then reset clears
    cycle(1'b0, 1'b0, 6'b111111, 6'd1);
    cycle(1'b0, 1'b0, 6'b010101, 6'd3);
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 6'b011111, 6'd1);
    // Randomized traffic with occasional mid-stream reset
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      cycle(r, v, a, b);
    end
    cycle(1'b0, 1'b0, '0, '0);
    cycle(1'b0, 1'b0, '0, '0);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    checks++;
    if (pulses != pushed) begin
      failures++;
      $display("FAIL pulse_count got=%0d expected=%0d", pulses, pushed);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
